// File: rtl/mc_rr_fifo_arb.sv
// Multi-channel FIFO buffer with a round-robin merger into one registered,
// channel-tagged output stream.
module mc_rr_fifo_arb #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned W     = 10,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(NCH),
  localparam int unsigned LW   = $clog2(DEPTH + 1)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [W-1:0]   in_data_i  [NCH],
  input  logic [NCH-1:0] in_valid_i,
  output logic [NCH-1:0] in_ready_o,
  output logic [W-1:0]   out_data_o,
  output logic [CW-1:0]  out_ch_o,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [LW-1:0]  level_o    [NCH]
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]   mem_q    [NCH][DEPTH];
  logic [PW-1:0]  wr_ptr_q [NCH];
  logic [PW-1:0]  wr_ptr_d [NCH];
  logic [PW-1:0]  rd_ptr_q [NCH];
  logic [PW-1:0]  rd_ptr_d [NCH];
  logic [LW-1:0]  count_q  [NCH];
  logic [LW-1:0]  count_d  [NCH];

  logic [NCH-1:0] full;
  logic [NCH-1:0] nonempty;
  logic [NCH-1:0] push;
  logic [NCH-1:0] pop;

  logic [CW-1:0]  rr_q, rr_d;
  logic [CW-1:0]  grant;
  logic           grant_vld;
  logic           load;
  logic [W-1:0]   head;

  logic [W-1:0]   out_data_q, out_data_d;
  logic [CW-1:0]  out_ch_q, out_ch_d;
  logic           out_valid_q, out_valid_d;

  // Ready depends only on the registered count: a full channel never accepts,
  // even when it is being drained in the same cycle.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      full[i]     = (count_q[i] == LW'(DEPTH));
      nonempty[i] = (count_q[i] != '0);
      level_o[i]  = count_q[i];
    end
  end

  assign in_ready_o = ~full;
  assign push       = in_valid_i & ~full;

  // First non-empty channel after the last grant, wrapping around.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant     = '0;
    grant_vld = 1'b0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NCH) begin
        idx = idx - NCH;
      end
      if (!grant_vld && nonempty[CW'(idx)]) begin
        grant_vld = 1'b1;
        grant     = CW'(idx);
      end
    end
  end

  assign load = (!out_valid_q || out_ready_i) && grant_vld;

  always_comb begin
    pop = '0;
    if (load) begin
      pop[grant] = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i] + PW'(push[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop[i]);
      count_d[i]  = count_q[i] + LW'(push[i]) - LW'(pop[i]);
    end
  end

  assign head = mem_q[grant][rd_ptr_q[grant]];

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_d        = rr_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = head;
      out_ch_d    = grant;
      rr_d        = grant;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NCH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      rr_q        <= CW'(NCH - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  // Storage is written only for accepted words, so idle-lane data never lands.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NCH; i++) begin
      if (!rst_i && push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= in_data_i[i];
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_ch_o    = out_ch_q;

endmodule

// File: tb/tb_mc_rr_fifo_arb.sv
// Self-checking bench for mc_rr_fifo_arb: vector table, directed corner cases
// and randomized traffic against a queue-based reference model.
module tb_mc_rr_fifo_arb;

  localparam int unsigned NCH   = 4;
  localparam int unsigned W     = 10;
  localparam int unsigned DEPTH = 4;

  logic           clk;
  logic           rst;
  logic [W-1:0]   in_data  [NCH];
  logic [NCH-1:0] in_valid;
  logic [NCH-1:0] in_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_ch;
  logic           out_valid;
  logic           out_ready;
  logic [2:0]     level    [NCH];

  int checks   = 0;
  int failures = 0;

  mc_rr_fifo_arb #(
    .NCH   (NCH),
    .W     (W),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_data_o  (out_data),
    .out_ch_o    (out_ch),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .level_o     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one queue per channel plus the output register contents.
  logic [W-1:0]   mq [NCH][$];
  logic           m_ov  = 1'b0;
  logic [W-1:0]   m_od  = '0;
  logic [1:0]     m_och = '0;
  int             m_rr  = NCH - 1;
  logic [NCH-1:0] m_acc = '0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic model_step();
    int  c;
    bit  found;
    if (rst) begin
      for (int i = 0; i < NCH; i++) mq[i].delete();
      m_ov  = 1'b0;
      m_od  = '0;
      m_och = '0;
      m_rr  = NCH - 1;
      m_acc = '0;
    end else begin
      for (int i = 0; i < NCH; i++) m_acc[i] = in_valid[i] && (mq[i].size() < DEPTH);
      if (!m_ov || out_ready) begin
        found = 0;
        for (int k = 1; k <= NCH; k++) begin
          c = (m_rr + k) % NCH;
          if (!found && mq[c].size() > 0) begin
            found = 1;
            m_od  = mq[c].pop_front();
            m_och = 2'(c);
            m_ov  = 1'b1;
            m_rr  = c;
          end
        end
        if (!found && out_ready) m_ov = 1'b0;
      end
      for (int i = 0; i < NCH; i++) if (m_acc[i]) mq[i].push_back(in_data[i]);
    end
  endtask

  task automatic compare_all();
    logic [NCH-1:0] exp_rdy;
    check("model_out_valid", 32'(out_valid), 32'(m_ov));
    check("model_out_ch", 32'(out_ch), 32'(m_och));
    check("model_out_data", 32'(out_data), 32'(m_od));
    for (int i = 0; i < NCH; i++) begin
      exp_rdy[i] = (mq[i].size() != DEPTH);
      check($sformatf("model_level%0d", i), 32'(level[i]), 32'(mq[i].size()));
    end
    check("model_in_ready", 32'(in_ready), 32'(exp_rdy));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [W-1:0] wd(int c, int j);
    return 10'h200 | 10'(c << 4) | 10'(j);
  endfunction

  typedef struct {
    logic           rst;
    logic [NCH-1:0] vld;
    logic [W-1:0]   dat;
    logic           ordy;
    logic           ov;
    logic [1:0]     och;
    logic [W-1:0]   od;
    logic [2:0]     l0, l1, l2, l3;
    logic [NCH-1:0] irdy;
  } vec_t;

  vec_t tbl [11];
  logic [NCH-1:0] pend;
  int thr;

  initial begin
    tbl[0]  = '{1'b1, 4'b0000, 10'h000, 1'b0, 1'b0, 2'd0, 10'h000, 3'd0, 3'd0, 3'd0, 3'd0, 4'hF};
    tbl[1]  = '{1'b1, 4'b0000, 10'h000, 1'b0, 1'b0, 2'd0, 10'h000, 3'd0, 3'd0, 3'd0, 3'd0, 4'hF};
    tbl[2]  = '{1'b0, 4'b0000, 10'h000, 1'b0, 1'b0, 2'd0, 10'h000, 3'd0, 3'd0, 3'd0, 3'd0, 4'hF};
    tbl[3]  = '{1'b0, 4'b0100, 10'h2A3, 1'b1, 1'b0, 2'd0, 10'h000, 3'd0, 3'd0, 3'd1, 3'd0, 4'hF};
    tbl[4]  = '{1'b0, 4'b0000, 10'h000, 1'b1, 1'b1, 2'd2, 10'h2A5, 3'd0, 3'd0, 3'd0, 3'd0, 4'hF};
    tbl[5]  = '{1'b0, 4'b0000, 10'h000, 1'b1, 1'b0, 2'd2, 10'h2A5, 3'd0, 3'd0, 3'd0, 3'd0, 4'hF};
    tbl[6]  = '{1'b0, 4'b0011, 10'h100, 1'b0, 1'b0, 2'd2, 10'h2A5, 3'd1, 3'd1, 3'd0, 3'd0, 4'hF};
    tbl[7]  = '{1'b0, 4'b0000, 10'h000, 1'b0, 1'b1, 2'd0, 10'h100, 3'd0, 3'd1, 3'd0, 3'd0, 4'hF};
    tbl[8]  = '{1'b0, 4'b0000, 10'h000, 1'b0, 1'b1, 2'd0, 10'h100, 3'd0, 3'd1, 3'd0, 3'd0, 4'hF};
    tbl[9]  = '{1'b0, 4'b0000, 10'h000, 1'b1, 1'b1, 2'd1, 10'h101, 3'd0, 3'd0, 3'd0, 3'd0, 4'hF};
    tbl[10] = '{1'b0, 4'b0000, 10'h000, 1'b1, 1'b0, 2'd1, 10'h101, 3'd0, 3'd0, 3'd0, 3'd0, 4'hF};

    rst       = 1'b1;
    in_valid  = '0;
    out_ready = 1'b0;
    for (int i = 0; i < NCH; i++) in_data[i] = '0;

    for (int n = 0; n < 11; n++) begin
      rst       = tbl[n].rst;
      in_valid  = tbl[n].vld;
      out_ready = tbl[n].ordy;
      for (int i = 0; i < NCH; i++) in_data[i] = tbl[n].dat + 10'(i);
      tick();
      check($sformatf("vec%0d_out_valid", n), 32'(out_valid), 32'(tbl[n].ov));
      check($sformatf("vec%0d_out_ch", n), 32'(out_ch), 32'(tbl[n].och));
      check($sformatf("vec%0d_out_data", n), 32'(out_data), 32'(tbl[n].od));
      check($sformatf("vec%0d_level0", n), 32'(level[0]), 32'(tbl[n].l0));
      check($sformatf("vec%0d_level1", n), 32'(level[1]), 32'(tbl[n].l1));
      check($sformatf("vec%0d_level2", n), 32'(level[2]), 32'(tbl[n].l2));
      check($sformatf("vec%0d_level3", n), 32'(level[3]), 32'(tbl[n].l3));
      check($sformatf("vec%0d_in_ready", n), 32'(in_ready), 32'(tbl[n].irdy));
    end

    // Fairness: three words per channel, then continuous drain.
    do_reset();
    for (int j = 0; j < 3; j++) begin
      in_valid = 4'hF;
      for (int c = 0; c < NCH; c++) in_data[c] = wd(c, j);
      tick();
    end
    in_valid = '0;
    check("fair_first_valid", 32'(out_valid), 32'd1);
    check("fair_first_ch", 32'(out_ch), 32'd0);
    check("fair_first_data", 32'(out_data), 32'(wd(0, 0)));
    out_ready = 1'b1;
    for (int k = 1; k < 12; k++) begin
      tick();
      check($sformatf("fair%0d_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("fair%0d_ch", k), 32'(out_ch), 32'(k % NCH));
      check($sformatf("fair%0d_data", k), 32'(out_data), 32'(wd(k % NCH, k / NCH)));
    end
    tick();
    check("fair_drained_valid", 32'(out_valid), 32'd0);

    // Full channel under backpressure, then release.
    do_reset();
    for (int j = 0; j < 5; j++) begin
      in_valid   = 4'b0010;
      in_data[1] = wd(1, j);
      tick();
    end
    check("bp_level1_full", 32'(level[1]), 32'd4);
    check("bp_in_ready1", 32'(in_ready[1]), 32'd0);
    in_data[1] = wd(1, 5);
    for (int t = 0; t < 10; t++) begin
      tick();
      check($sformatf("bp_stall%0d_data", t), 32'(out_data), 32'(wd(1, 0)));
      check($sformatf("bp_stall%0d_valid", t), 32'(out_valid), 32'd1);
      check($sformatf("bp_stall%0d_level1", t), 32'(level[1]), 32'd4);
    end
    in_valid  = '0;
    out_ready = 1'b1;
    for (int j = 1; j < 5; j++) begin
      tick();
      check($sformatf("bp_drain%0d_data", j), 32'(out_data), 32'(wd(1, j)));
    end
    tick();
    check("bp_done_valid", 32'(out_valid), 32'd0);

    // Push into a full channel while it is being popped.
    do_reset();
    for (int j = 0; j < 5; j++) begin
      in_valid   = 4'b1000;
      in_data[3] = wd(3, j);
      tick();
    end
    out_ready  = 1'b1;
    in_data[3] = wd(3, 5);
    check("pp_in_ready3_full", 32'(in_ready[3]), 32'd0);
    tick();
    check("pp_level3_after_pop", 32'(level[3]), 32'd3);
    check("pp_data1", 32'(out_data), 32'(wd(3, 1)));
    check("pp_in_ready3_open", 32'(in_ready[3]), 32'd1);
    tick();
    check("pp_level3_pushpop", 32'(level[3]), 32'd3);
    check("pp_data2", 32'(out_data), 32'(wd(3, 2)));
    in_valid = '0;
    for (int j = 3; j < 6; j++) begin
      tick();
      check($sformatf("pp_data%0d", j), 32'(out_data), 32'(wd(3, j)));
      check($sformatf("pp_level3_%0d", j), 32'(level[3]), 32'(5 - j));
    end

    // Reset while output is stalled and ch0 holds words.
    do_reset();
    for (int j = 0; j < 3; j++) begin
      in_valid   = 4'b0001;
      in_data[0] = wd(0, j);
      tick();
    end
    in_valid = '0;
    check("mr_pre_valid", 32'(out_valid), 32'd1);
    check("mr_pre_level0", 32'(level[0]), 32'd2);
    rst = 1'b1;
    tick();
    check("mr_post_valid", 32'(out_valid), 32'd0);
    check("mr_post_level0", 32'(level[0]), 32'd0);
    rst        = 1'b0;
    in_valid   = 4'b0011;
    in_data[0] = wd(0, 7);
    in_data[1] = wd(1, 7);
    tick();
    in_valid = '0;
    tick();
    check("mr_first_grant_ch", 32'(out_ch), 32'd0);
    check("mr_first_grant_data", 32'(out_data), 32'(wd(0, 7)));

    // Randomized traffic with held offers, varying drain rate, rare resets.
    do_reset();
    pend = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      thr       = ((cyc / 500) % 3) * 4 + 2;
      rst       = ($urandom_range(0, 299) == 0);
      out_ready = ($urandom_range(0, 9) < thr);
      for (int i = 0; i < NCH; i++) begin
        if (!pend[i]) begin
          in_data[i] = 10'($urandom);
          if ($urandom_range(0, 2) == 0) pend[i] = 1'b1;
        end
      end
      in_valid = pend;
      tick();
      pend = pend & ~m_acc;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
